// File: rtl/pe_ml_pkg.sv
// Shared defaults, types and helpers for the multi-lane rate-coded inner-product PE.
// The lanes also compile with PE_SAT_EN defined, which makes the partial-sum merge saturate.
package pe_ml_pkg;

    localparam int IWIDTH_D = 16;
    localparam int OWIDTH_D = 24;
    localparam int LANES_D  = 4;

    typedef logic [IWIDTH_D-1:0]        wght_t;
    typedef logic signed [OWIDTH_D-1:0] psum_t;

    // Symmetric saturation: the most negative code is never produced.
    function automatic psum_t sat_add(input psum_t a, input psum_t b);
        logic signed [OWIDTH_D:0] s;
        logic signed [OWIDTH_D:0] lim;
        s   = {a[OWIDTH_D-1], a} + {b[OWIDTH_D-1], b};
        lim = {2'b00, {(OWIDTH_D-1){1'b1}}};
        if (s > lim)
            return psum_t'(lim);
        else if (s < -lim)
            return psum_t'(-lim);
        else
            return s[OWIDTH_D-1:0];
    endfunction

endpackage

// File: rtl/pe_lane.sv
// One output channel: weight register, comparator multiplier, saturating accumulator and merge.
// With PE_SAT_EN defined the merge saturates and drives a sticky ovf flag.
module pe_lane
    import pe_ml_pkg::*;
#(
    parameter int IWIDTH = IWIDTH_D,
    parameter int OWIDTH = OWIDTH_D
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_w,
    input  logic                     clr_w,
    input  logic                     en_o,
    input  logic                     clr_o,
    input  logic                     mac_done_d,
    input  logic                     ifm_bit_d,
    input  logic [IWIDTH-1:0]        randW,
    input  logic [IWIDTH-1:0]        wght,
    input  logic                     wght_sign,
    input  logic signed [OWIDTH-1:0] ofm,
    output logic [IWIDTH-1:0]        wght_d,
    output logic                     wght_sign_d,
    output logic signed [OWIDTH-1:0] ofm_d
`ifdef PE_SAT_EN
    ,
    output logic                     ovf
`endif
);

    localparam logic signed [OWIDTH:0] XMAX = {2'b00, {(OWIDTH-1){1'b1}}};
    localparam logic signed [OWIDTH:0] XMIN = -XMAX;
    localparam logic signed [OWIDTH:0] XONE = 1;

    function automatic logic signed [OWIDTH-1:0] clip(input logic signed [OWIDTH:0] s);
        if (s > XMAX)
            return XMAX[OWIDTH-1:0];
        else if (s < XMIN)
            return XMIN[OWIDTH-1:0];
        else
            return s[OWIDTH-1:0];
    endfunction

    logic                     prod;
    logic signed [OWIDTH-1:0] acc;
    logic signed [OWIDTH:0]   acc_ext;
    logic signed [OWIDTH:0]   step;
    logic signed [OWIDTH-1:0] acc_next;
    logic signed [OWIDTH-1:0] merge;
`ifdef PE_SAT_EN
    logic signed [OWIDTH:0]   merge_sum;
    logic                     merge_sat;
`endif

    // The comparator sees this cycle's randW while the weight is the registered one.
    assign prod = ifm_bit_d & (wght_d > randW);

    always_comb begin
        step = '0;
        if (en_o && prod)
            step = wght_sign_d ? -XONE : XONE;
        acc_ext  = {acc[OWIDTH-1], acc};
        acc_next = clip(acc_ext + step);
`ifdef PE_SAT_EN
        merge_sum = {acc_next[OWIDTH-1], acc_next} + {ofm[OWIDTH-1], ofm};
        merge     = clip(merge_sum);
        merge_sat = (merge_sum > XMAX) || (merge_sum < XMIN);
`else
        merge     = acc_next + ofm;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wght_d      <= '0;
            wght_sign_d <= 1'b0;
        end else if (clr_w) begin
            wght_d      <= '0;
            wght_sign_d <= 1'b0;
        end else if (en_w) begin
            wght_d      <= wght;
            wght_sign_d <= wght_sign;
        end
    end

    // A merge folds in the current cycle's product, so it uses acc_next even when clr_o is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            ofm_d <= '0;
        end else begin
            if (mac_done_d)
                ofm_d <= merge;
            if (mac_done_d || clr_o)
                acc <= '0;
            else
                acc <= acc_next;
        end
    end

`ifdef PE_SAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf <= 1'b0;
        else if (mac_done_d && merge_sat)
            ovf <= 1'b1;
        else if (clr_o)
            ovf <= 1'b0;
    end
`endif

endmodule

// File: rtl/pe_inner_ml.sv
// Multi-lane rate-coded inner-product PE: shared unary input, LANES weights and accumulators.
// Define PE_SAT_EN for a saturating partial-sum merge and the per-lane sticky ovf output.
module pe_inner_ml
    import pe_ml_pkg::*;
#(
    parameter int IWIDTH = IWIDTH_D,
    parameter int OWIDTH = OWIDTH_D,
    parameter int LANES  = LANES_D
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mac_done,
    input  logic                      en_i,
    input  logic                      clr_i,
    input  logic                      en_w,
    input  logic                      clr_w,
    input  logic                      en_o,
    input  logic                      clr_o,
    input  logic                      ifm_bit,
    input  logic [IWIDTH-1:0]         randW,
    input  logic [LANES*IWIDTH-1:0]   wght,
    input  logic [LANES-1:0]          wght_sign,
    input  logic [LANES*OWIDTH-1:0]   ofm,
    output logic                      mac_done_d,
    output logic                      en_i_d,
    output logic                      clr_i_d,
    output logic                      en_w_d,
    output logic                      clr_w_d,
    output logic                      en_o_d,
    output logic                      clr_o_d,
    output logic                      ifm_bit_d,
    output logic [IWIDTH-1:0]         randW_d,
    output logic [LANES*IWIDTH-1:0]   wght_d,
    output logic [LANES-1:0]          wght_sign_d,
    output logic [LANES*OWIDTH-1:0]   ofm_d
`ifdef PE_SAT_EN
    ,
    output logic [LANES-1:0]          ovf
`endif
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_done_d <= 1'b0;
            en_i_d     <= 1'b0;
            clr_i_d    <= 1'b0;
            en_w_d     <= 1'b0;
            clr_w_d    <= 1'b0;
            en_o_d     <= 1'b0;
            clr_o_d    <= 1'b0;
            randW_d    <= '0;
        end else begin
            mac_done_d <= mac_done;
            en_i_d     <= en_i;
            clr_i_d    <= clr_i;
            en_w_d     <= en_w;
            clr_w_d    <= clr_w;
            en_o_d     <= en_o;
            clr_o_d    <= clr_o;
            randW_d    <= randW;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ifm_bit_d <= 1'b0;
        else if (clr_i)
            ifm_bit_d <= 1'b0;
        else if (en_i)
            ifm_bit_d <= ifm_bit;
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        pe_lane #(
            .IWIDTH(IWIDTH),
            .OWIDTH(OWIDTH)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .en_w       (en_w),
            .clr_w      (clr_w),
            .en_o       (en_o),
            .clr_o      (clr_o),
            .mac_done_d (mac_done_d),
            .ifm_bit_d  (ifm_bit_d),
            .randW      (randW),
            .wght       (wght[l*IWIDTH +: IWIDTH]),
            .wght_sign  (wght_sign[l]),
            .ofm        (ofm[l*OWIDTH +: OWIDTH]),
            .wght_d     (wght_d[l*IWIDTH +: IWIDTH]),
            .wght_sign_d(wght_sign_d[l]),
`ifdef PE_SAT_EN
            .ovf        (ovf[l]),
`endif
            .ofm_d      (ofm_d[l*OWIDTH +: OWIDTH])
        );
    end

endmodule

// File: tb/tb_pe_inner_ml.sv
// Scoreboard bench for pe_inner_ml: a default-size DUT against an arithmetic reference model,
// plus a narrow 8-bit DUT for accumulator and merge overflow. Honours PE_SAT_EN.
module tb_pe_inner_ml;

    localparam int IW = 16;
    localparam int OW = 24;
    localparam int LN = 4;
    localparam int SW = 8;
    localparam longint MAXV  = (longint'(1) << (OW - 1)) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic               mac_done, en_i, clr_i, en_w, clr_w, en_o, clr_o, ifm_bit;
    logic [IW-1:0]      randW;
    logic [LN*IW-1:0]   wght;
    logic [LN-1:0]      wght_sign;
    logic [LN*OW-1:0]   ofm;
    logic               mac_done_d, en_i_d, clr_i_d, en_w_d, clr_w_d, en_o_d, clr_o_d, ifm_bit_d;
    logic [IW-1:0]      randW_d;
    logic [LN*IW-1:0]   wght_d;
    logic [LN-1:0]      wght_sign_d;
    logic [LN*OW-1:0]   ofm_d;
`ifdef PE_SAT_EN
    logic [LN-1:0]      ovf;
`endif

    logic               s_mac_done, s_en_i, s_clr_i, s_en_w, s_clr_w, s_en_o, s_clr_o, s_ifm_bit;
    logic [IW-1:0]      s_randW;
    logic [IW-1:0]      s_wght;
    logic [0:0]         s_wght_sign;
    logic [SW-1:0]      s_ofm;
    logic               s_mac_done_d, s_en_i_d, s_clr_i_d, s_en_w_d, s_clr_w_d, s_en_o_d, s_clr_o_d;
    logic               s_ifm_bit_d;
    logic [IW-1:0]      s_randW_d;
    logic [IW-1:0]      s_wght_d;
    logic [0:0]         s_wght_sign_d;
    logic [SW-1:0]      s_ofm_d;
`ifdef PE_SAT_EN
    logic [0:0]         s_ovf;
`endif

    pe_inner_ml #(.IWIDTH(IW), .OWIDTH(OW), .LANES(LN)) dut (
        .clk(clk), .rst(rst), .mac_done(mac_done), .en_i(en_i), .clr_i(clr_i),
        .en_w(en_w), .clr_w(clr_w), .en_o(en_o), .clr_o(clr_o), .ifm_bit(ifm_bit),
        .randW(randW), .wght(wght), .wght_sign(wght_sign), .ofm(ofm),
        .mac_done_d(mac_done_d), .en_i_d(en_i_d), .clr_i_d(clr_i_d), .en_w_d(en_w_d),
        .clr_w_d(clr_w_d), .en_o_d(en_o_d), .clr_o_d(clr_o_d), .ifm_bit_d(ifm_bit_d),
        .randW_d(randW_d), .wght_d(wght_d), .wght_sign_d(wght_sign_d),
`ifdef PE_SAT_EN
        .ovf(ovf),
`endif
        .ofm_d(ofm_d)
    );

    pe_inner_ml #(.IWIDTH(IW), .OWIDTH(SW), .LANES(1)) dut_small (
        .clk(clk), .rst(rst), .mac_done(s_mac_done), .en_i(s_en_i), .clr_i(s_clr_i),
        .en_w(s_en_w), .clr_w(s_clr_w), .en_o(s_en_o), .clr_o(s_clr_o), .ifm_bit(s_ifm_bit),
        .randW(s_randW), .wght(s_wght), .wght_sign(s_wght_sign), .ofm(s_ofm),
        .mac_done_d(s_mac_done_d), .en_i_d(s_en_i_d), .clr_i_d(s_clr_i_d), .en_w_d(s_en_w_d),
        .clr_w_d(s_clr_w_d), .en_o_d(s_en_o_d), .clr_o_d(s_clr_o_d), .ifm_bit_d(s_ifm_bit_d),
        .randW_d(s_randW_d), .wght_d(s_wght_d), .wght_sign_d(s_wght_sign_d),
`ifdef PE_SAT_EN
        .ovf(s_ovf),
`endif
        .ofm_d(s_ofm_d)
    );

    int n_cmp = 0;
    int n_fail = 0;
    longint exp_q[$];

    // Reference state: what each register should hold after the last clock edge.
    logic [6:0]    m_ctrl;
    logic          m_ifm;
    logic [IW-1:0] m_randW;
    logic [IW-1:0] m_w [LN];
    logic          m_s [LN];
    longint        m_acc [LN];
    longint        m_ofm [LN];
    logic          m_ovf [LN];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint lane_ofm_d(input int l);
        logic signed [OW-1:0] t;
        t = ofm_d[l*OW +: OW];
        return longint'(t);
    endfunction

    function automatic longint lane_ofm_in(input int l);
        logic signed [OW-1:0] t;
        t = ofm[l*OW +: OW];
        return longint'(t);
    endfunction

    function automatic longint wrap_ow(input longint v);
        logic signed [OW-1:0] t;
        t = v[OW-1:0];
        return longint'(t);
    endfunction

    task automatic modelReset();
        m_ctrl  = '0;
        m_ifm   = 1'b0;
        m_randW = '0;
        for (int l = 0; l < LN; l++) begin
            m_w[l] = '0; m_s[l] = 1'b0; m_acc[l] = 0; m_ofm[l] = 0; m_ovf[l] = 1'b0;
        end
        exp_q.delete();
    endtask

    // Advance the reference by one clock edge using the inputs currently driven.
    task automatic modelStep();
        longint an, res;
        logic   prod, sat;
        for (int l = 0; l < LN; l++) begin
            prod = m_ifm && (m_w[l] > randW);
            an = m_acc[l];
            if (en_o && prod) an = an + (m_s[l] ? -1 : 1);
            if (an > MAXV) an = MAXV;
            if (an < -MAXV) an = -MAXV;
            sat = 1'b0;
            if (m_ctrl[6]) begin
                res = an + lane_ofm_in(l);
`ifdef PE_SAT_EN
                if (res > MAXV) begin res = MAXV; sat = 1'b1; end
                if (res < -MAXV) begin res = -MAXV; sat = 1'b1; end
`else
                res = wrap_ow(res);
`endif
                m_ofm[l] = res;
                exp_q.push_back(res);
            end
            m_ovf[l] = sat ? 1'b1 : (clr_o ? 1'b0 : m_ovf[l]);
            m_acc[l] = (m_ctrl[6] || clr_o) ? 0 : an;
            if (clr_w) begin
                m_w[l] = '0; m_s[l] = 1'b0;
            end else if (en_w) begin
                m_w[l] = wght[l*IW +: IW]; m_s[l] = wght_sign[l];
            end
        end
        m_ifm   = clr_i ? 1'b0 : (en_i ? ifm_bit : m_ifm);
        m_randW = randW;
        m_ctrl  = {mac_done, en_i, clr_i, en_w, clr_w, en_o, clr_o};
    endtask

    task automatic checkOutput();
        check("ctrl_fwd", longint'({mac_done_d, en_i_d, clr_i_d, en_w_d, clr_w_d, en_o_d, clr_o_d}),
              longint'(m_ctrl));
        check("ifm_bit_d", longint'(ifm_bit_d), longint'(m_ifm));
        check("randW_d", longint'(randW_d), longint'(m_randW));
        for (int l = 0; l < LN; l++) begin
            check($sformatf("wght_d[%0d]", l), longint'(wght_d[l*IW +: IW]), longint'(m_w[l]));
            check($sformatf("wght_sign_d[%0d]", l), longint'(wght_sign_d[l]), longint'(m_s[l]));
            check($sformatf("ofm_d_hold[%0d]", l), lane_ofm_d(l), m_ofm[l]);
`ifdef PE_SAT_EN
            check($sformatf("ovf[%0d]", l), longint'(ovf[l]), longint'(m_ovf[l]));
`endif
        end
    endtask

    // Called at a negedge with inputs set; returns at the next negedge after checking.
    task automatic applyStimulus();
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle();
        {mac_done, en_i, clr_i, en_w, clr_w, en_o, clr_o, ifm_bit} = '0;
        randW = '0;
        ofm   = '0;
    endtask

    // Monitor: one negedge after mac_done_d was seen high, ofm_d carries a merge result.
    initial begin
        bit seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
            end else begin
                if (seen) begin
                    for (int l = 0; l < LN; l++) begin
                        if (exp_q.size() == 0)
                            check($sformatf("sb_missing[%0d]", l), lane_ofm_d(l), -1);
                        else
                            check($sformatf("sb_ofm_d[%0d]", l), lane_ofm_d(l), exp_q.pop_front());
                    end
                end
                seen = mac_done_d;
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle();
        wght = '0; wght_sign = '0;
        {s_mac_done, s_en_i, s_clr_i, s_en_w, s_clr_w, s_en_o, s_clr_o, s_ifm_bit} = '0;
        s_randW = '0; s_wght = '0; s_wght_sign = '0; s_ofm = '0;
        modelReset();
        repeat (2) @(negedge clk);
        check("reset_ofm_d", longint'(|ofm_d), 0);
        rst = 1'b0;
        applyStimulus();

        // Build up ofm_d=5 and acc=37, then reset asynchronously mid-cycle.
        wght = {4{16'h8000}}; wght_sign = '0;
        en_w = 1'b1; en_i = 1'b1; ifm_bit = 1'b1; clr_o = 1'b1;
        applyStimulus();
        idle(); mac_done = 1'b1;
        applyStimulus();
        idle(); ofm = {4{24'd5}};
        applyStimulus();
        check("pre_rst_ofm_d", lane_ofm_d(1), 5);
        idle(); en_o = 1'b1;
        repeat (37) applyStimulus();
        idle();
        #2 rst = 1'b1;
        #1;
        check("rst_async_ofm_d", lane_ofm_d(1), 0);
        check("rst_async_any", longint'(|{mac_done_d, en_i_d, clr_i_d, en_w_d, clr_w_d, en_o_d,
              clr_o_d, ifm_bit_d, randW_d, wght_d, wght_sign_d, ofm_d}), 0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        mac_done = 1'b1;
        applyStimulus();
        idle();
        applyStimulus();
        check("post_rst_acc_clear", lane_ofm_d(1), 0);

        // Deterministic sweep of randW over the whole range.
        wght = {16'h4000, 16'hFFFF, 16'h8000, 16'h0000}; wght_sign = 4'b0100;
        en_w = 1'b1; en_i = 1'b1; ifm_bit = 1'b1; clr_o = 1'b1;
        applyStimulus();
        idle(); en_o = 1'b1;
        for (int r = 0; r < 65536; r++) begin
            randW = IW'(r);
            applyStimulus();
        end
        idle(); mac_done = 1'b1;
        applyStimulus();
        idle();
        applyStimulus();
        check("sweep_w0", lane_ofm_d(0), 0);
        check("sweep_w8000", lane_ofm_d(1), 32768);
        check("sweep_wFFFF_neg", lane_ofm_d(2), -65535);
        check("sweep_w4000", lane_ofm_d(3), 16384);

        // Clear wins over enable on both the weight and input registers.
        wght = {4{16'h1234}}; wght_sign = 4'b1111;
        en_w = 1'b1; clr_w = 1'b1; en_i = 1'b1; clr_i = 1'b1; ifm_bit = 1'b1;
        applyStimulus();
        check("clr_w_prio", longint'(wght_d), 0);
        check("clr_w_sign_prio", longint'(wght_sign_d), 0);
        check("clr_i_prio", longint'(ifm_bit_d), 0);

        // acc=9, then merge, clr_o and a +1 product on the same edge.
        idle();
        wght = {4{16'hFFFF}}; wght_sign = '0;
        en_w = 1'b1; en_i = 1'b1; ifm_bit = 1'b1; clr_o = 1'b1;
        applyStimulus();
        idle(); en_o = 1'b1;
        repeat (9) applyStimulus();
        idle(); mac_done = 1'b1;
        applyStimulus();
        idle(); en_o = 1'b1; clr_o = 1'b1; ofm = {4{24'd100}};
        applyStimulus();
        check("simul_merge", lane_ofm_d(0), 110);
        idle(); mac_done = 1'b1;
        applyStimulus();
        idle();
        applyStimulus();
        check("simul_acc_cleared", lane_ofm_d(0), 0);

        // Random traffic on every input.
        for (int c = 0; c < 1000; c++) begin
            mac_done  = ($urandom_range(15, 0) == 0);
            clr_o     = ($urandom_range(31, 0) == 0);
            en_o      = ($urandom_range(3, 0) != 0);
            en_i      = 1'($urandom);
            clr_i     = ($urandom_range(7, 0) == 0);
            en_w      = ($urandom_range(7, 0) == 0);
            clr_w     = ($urandom_range(31, 0) == 0);
            ifm_bit   = 1'($urandom);
            randW     = IW'($urandom);
            wght      = {$urandom(), $urandom()};
            wght_sign = LN'($urandom);
            ofm       = {$urandom(), $urandom(), $urandom()};
            applyStimulus();
        end
        idle();
        repeat (2) applyStimulus();

        // Narrow 8-bit instance: merge overflow, then accumulator saturation.
        s_en_w = 1'b1; s_wght = 16'hFFFF; s_en_i = 1'b1; s_ifm_bit = 1'b1; s_randW = '0;
        @(negedge clk);
        s_en_w = 1'b0; s_en_i = 1'b0; s_en_o = 1'b1;
        repeat (120) @(negedge clk);
        s_en_o = 1'b0; s_mac_done = 1'b1;
        @(negedge clk);
        s_mac_done = 1'b0; s_ofm = 8'd20;
        @(negedge clk);
`ifdef PE_SAT_EN
        check("ovf8_sat", longint'($signed(s_ofm_d)), 127);
        check("ovf8_flag", longint'(s_ovf), 1);
`else
        check("ovf8_wrap", longint'($signed(s_ofm_d)), -116);
`endif
        s_ofm = '0; s_en_o = 1'b1;
        repeat (200) @(negedge clk);
        s_en_o = 1'b0; s_mac_done = 1'b1;
        @(negedge clk);
        s_mac_done = 1'b0;
        @(negedge clk);
        check("acc8_saturates", longint'($signed(s_ofm_d)), 127);
`ifdef PE_SAT_EN
        s_clr_o = 1'b1;
        @(negedge clk);
        s_clr_o = 1'b0;
        check("ovf8_cleared", longint'(s_ovf), 0);
`endif

        check("sb_drained", longint'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_inner_ml.md
Name: pe_inner_ml

Overview:
- Multi-lane successor to the rate-coded inner-product PE of the ugemmrate systolic array.
- One unary input bit-stream is shared across LANES output channels. Each lane has its own weight register, comparator-based stochastic multiplier and signed accumulator.
- Control, random numbers and weights are forwarded systolically with one-cycle delay. Partial sums from the upstream PE are merged on mac_done.

Parameters:
- IWIDTH, 16, weight magnitude and random-number width
- OWIDTH, 24, per-lane accumulator and partial-sum width (signed)
- LANES, 4, parallel output channels per PE (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mac_done  in  1  end of MAC window; merge partial sum
- en_i, clr_i  in  1 each  input-bit register enable / clear
- en_w, clr_w  in  1 each  weight register enable / clear
- en_o, clr_o  in  1 each  accumulator enable / clear
- ifm_bit  in  1  unary input bit
- randW  in  IWIDTH  random number for weight comparison
- wght  in  LANES*IWIDTH  weight magnitudes, lane l at [l*IWIDTH +: IWIDTH]
- wght_sign  in  LANES  weight sign per lane (1 = negative)
- ofm  in  LANES*OWIDTH  upstream signed partial sums
- mac_done_d, en_i_d, clr_i_d, en_w_d, clr_w_d, en_o_d, clr_o_d  out  1 each  registered control forwards
- ifm_bit_d  out  1  registered input bit
- randW_d  out  IWIDTH  registered randW
- wght_d  out  LANES*IWIDTH  registered weights
- wght_sign_d  out  LANES  registered signs
- ofm_d  out  LANES*OWIDTH  merged partial sums

Behaviour:
- Reset: every output and internal register goes to 0 asynchronously while rst=1.
- Control forwards: each *_d equals its input delayed one cycle, unconditionally.
- randW_d: one-cycle delay of randW, unconditional.
- Input register: clr_i=1 -> 0. Else en_i=1 -> ifm_bit. Else hold. clr has priority over en.
- Weight register: clr_w=1 -> wght_d and wght_sign_d go to 0. Else en_w=1 -> load all lanes. Else hold.
- Multiplier, lane l (combinational):
  - wbit[l] = (wght_d[l] > randW), unsigned compare against the undelayed randW.
  - prod[l] = ifm_bit_d & wbit[l].
  - Weight 0 never fires. Weight 2^IWIDTH-1 fires unless randW = all-ones.
- Accumulator, lane l:
  - acc_next = acc + (en_o & prod[l] ? (wght_sign_d[l] ? -1 : +1) : 0).
  - clr_o=1 -> acc <= 0, taking priority over the increment.
- Merge, lane l, when mac_done_d=1:
  - ofm_d[l] <= acc_next + ofm[l], signed OWIDTH add. The current cycle's bit is included.
  - acc <= 0 in the same cycle.
  - If clr_o also = 1, ofm_d still uses acc_next.
- Otherwise ofm_d holds its value.
- Overflow: see PE_SAT_EN. The accumulator itself always saturates at +/-(2^(OWIDTH-1)-1); it never wraps.
- Latency: ifm_bit to prod is 1 cycle. Final bit to ofm_d is visible 1 cycle after mac_done_d.
- Lanes are fully independent apart from the shared ifm_bit_d and randW.

Optional Feature:
- Macro: PE_SAT_EN.
- Defined: the merge add saturates to [-(2^(OWIDTH-1)-1), 2^(OWIDTH-1)-1]. A sticky output ovf[LANES] sets on saturation and clears on clr_o or rst.
- Undefined: the merge add wraps two's-complement, and the ovf port is absent.

Decomposition:
- Package pe_ml_pkg holds:
  - localparam defaults IWIDTH_D, OWIDTH_D, LANES_D;
  - typedef wght_t (logic [IWIDTH-1:0]);
  - typedef psum_t (logic signed [OWIDTH-1:0]);
  - function sat_add (psum_t, psum_t) -> psum_t.
- Sub-module pe_lane: one lane's weight register, comparator, accumulator and merge, instantiated LANES times via generate.
- The top level holds the control forwards, input register and randW pipeline.

Test Plan:
- Reset mid-run: assert rst with acc=37 and ofm_d=5 -> all outputs are 0 the same cycle, before any clk edge.
- Deterministic MAC, LANES=4, weights {0, 0x8000, 0xFFFF, 0x4000}, signs {0,0,1,0}:
  - Stimulus: ifm_bit=1, randW sweeping 0..65535 with en_o=1, then mac_done, ofm=0.
  - Expected ofm_d = {0, 32768, -65535, 16384}, clipped to OWIDTH limits if narrower.
- Simultaneous events: mac_done_d, clr_o and a +1 product in the same cycle with acc=9 and ofm=100 -> ofm_d=110, acc=0 next cycle.
- Priority: clr_w and en_w asserted together -> wght_d=0. clr_i and en_i together -> ifm_bit_d=0.
- Overflow, OWIDTH=8, acc=120, ofm=20:
  - PE_SAT_EN defined -> ofm_d=127, ovf=1.
  - PE_SAT_EN undefined -> ofm_d=-116.
- Systolic forwarding: random toggling on all control inputs, randW and wght -> every *_d matches its input delayed exactly one cycle, over 1000 cycles.
